z16_instr_loader: RTL
=====================

Z16_INSTR_LOADER -- requirements
Module: z16_instr_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 32768, the maximum accepted program length in 16-bit words (range 1..32768).
REQ-002 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_byte  input  8  incoming program stream byte.
REQ-005 SHALL have port i_byte_valid  input  1  i_byte is valid this cycle.
REQ-006 SHALL have port o_byte_ready  output  1  loader accepts a byte this cycle; a byte transfers when i_byte_valid and o_byte_ready are both 1 at a rising edge.
REQ-007 SHALL have port o_mem_we  output  1  instruction memory write strobe, one cycle per word.
REQ-008 SHALL have port o_mem_addr  output  16  instruction memory byte address; always even, word index = o_mem_addr[15:1].
REQ-009 SHALL have port o_mem_wdata  output  16  instruction word to write.
REQ-010 SHALL have port o_cpu_hold  output  1  CPU held in reset while 1.
REQ-011 SHALL have port o_done  output  1  a valid program has been loaded.
REQ-012 SHALL have port o_error  output  1  the last load attempt failed.

Function
REQ-013 SHALL accept the frame: SYNC (0xA5), CNT_L, CNT_H, N words each sent low byte then high byte, CHK; N = {CNT_H, CNT_L}.
REQ-014 SHALL implement states IDLE, CNT_L, CNT_H, DATA_L, DATA_H, WRITE, CHK, DONE, ERR.
REQ-015 SHALL drive o_byte_ready = 1 in every state except WRITE.
REQ-016 IDLE, DONE, ERR: an accepted 0xA5 SHALL go to CNT_L, clear o_done and o_error, and set o_cpu_hold; any other accepted byte SHALL be discarded with no state change.
REQ-017 CNT_L -> CNT_H on accept; CNT_H -> DATA_L on accept when 1 <= N <= MAX_WORDS, -> CHK when N = 0, -> ERR when N > MAX_WORDS.
REQ-018 Entering DATA_L from CNT_H SHALL reset the word index and the 8-bit running checksum to 0.
REQ-019 DATA_L -> DATA_H on accept, latching the low byte; DATA_H -> WRITE on accept, latching the high byte.
REQ-020 Data bytes SHALL be added to the checksum modulo 256; SYNC, CNT_L, CNT_H and CHK SHALL NOT be added.
REQ-021 In WRITE (exactly one cycle), o_mem_we SHALL be 1, o_mem_addr = 2 x word index, o_mem_wdata = {high, low}; then the word index increments and the state goes to DATA_L when more words remain, else to CHK.
REQ-022 o_mem_we SHALL be 0 in all states except WRITE; o_mem_addr and o_mem_wdata are don't-care when o_mem_we = 0.
REQ-023 CHK: an accepted byte equal to the running checksum SHALL go to DONE, otherwise to ERR.
REQ-024 DONE: o_done = 1, o_cpu_hold = 0, o_error = 0. ERR: o_error = 1, o_cpu_hold = 1, o_done = 0.
REQ-025 o_cpu_hold SHALL be 1 in every state except DONE.
REQ-026 Words written before an error SHALL remain in memory; the loader performs no rollback.
REQ-027 0xA5 received in any state other than IDLE, DONE or ERR SHALL be treated as ordinary payload.
REQ-028 i_byte_valid held low SHALL stall the loader indefinitely in its current state, with no timeout.
REQ-029 The word index SHALL be 16 bits wide; MAX_WORDS bounds it, so the address never wraps.

Reset
REQ-030 While i_rst = 1, all state and outputs SHALL take reset values immediately, regardless of i_clk.
REQ-031 Reset values SHALL be: state IDLE, o_byte_ready 1, o_mem_we 0, o_mem_addr 0x0000, o_mem_wdata 0x0000, o_cpu_hold 1, o_done 0, o_error 0, word index 0, checksum 0.
REQ-032 A reset asserted mid-frame SHALL abort the load; a WRITE cycle coincident with reset SHALL NOT produce a write strobe.

Verification
REQ-033 Stream A5 02 00 10 00 19 01 2A -> writes 0x0010 @0x0000, then 0x0119 @0x0002; o_done = 1 and o_cpu_hold = 0 after the CHK byte (0x2A = 0x10 + 0x00 + 0x19 + 0x01).
REQ-034 Same stream with CHK = 0x2B -> two writes occur, then o_error = 1, o_cpu_hold = 1, o_done = 0.
REQ-035 Stream A5 00 00 00 -> no writes, o_done = 1; stream A5 00 00 01 -> o_error = 1.
REQ-036 Stream A5 with N = MAX_WORDS + 1 -> ERR immediately after CNT_H, no writes.
REQ-037 Stream 33 A5 01 00 34 12 46 with i_byte_valid held asserted -> 0x33 is ignored; one write of 0x1234 @0x0000; o_byte_ready = 0 exactly during the WRITE cycle; o_done = 1.
REQ-038 Assert i_rst between DATA_L and DATA_H of a word -> outputs return to reset values with no write; a subsequent full frame loads correctly.

Source files
------------

// File: rtl/z16_instr_loader.sv
`default_nettype none
//==============================================================================
// Module   : z16_instr_loader
// Purpose  : Byte-stream boot loader for the z16 instruction memory. Parses
//            frames of the form SYNC(0xA5), CNT_L, CNT_H, N x {lo, hi}, CHK,
//            writes each 16-bit word to instruction memory and holds the CPU
//            in reset until a frame with a matching 8-bit checksum arrives.
// Ports    : i_clk        - clock, rising edge
//            i_rst        - asynchronous active-high reset
//            i_byte       - incoming stream byte
//            i_byte_valid - i_byte valid this cycle
//            o_byte_ready - loader accepts a byte this cycle
//            o_mem_we     - instruction memory write strobe (one cycle/word)
//            o_mem_addr   - instruction memory byte address (always even)
//            o_mem_wdata  - instruction word to write
//            o_cpu_hold   - CPU held in reset while high
//            o_done       - valid program loaded
//            o_error      - last load attempt failed
// Revision : 1.0 - initial release
//==============================================================================
module z16_instr_loader #(
   parameter int unsigned MAX_WORDS = 32768
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_byte,
   input  logic        i_byte_valid,
   output logic        o_byte_ready,
   output logic        o_mem_we,
   output logic [15:0] o_mem_addr,
   output logic [15:0] o_mem_wdata,
   output logic        o_cpu_hold,
   output logic        o_done,
   output logic        o_error
);

   localparam logic [7:0]  c_SYNC      = 8'hA5;
   localparam logic [16:0] c_MAX_WORDS = 17'(MAX_WORDS);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_CNT_L  = 4'd1,
      S_CNT_H  = 4'd2,
      S_DATA_L = 4'd3,
      S_DATA_H = 4'd4,
      S_WRITE  = 4'd5,
      S_CHK    = 4'd6,
      S_DONE   = 4'd7,
      S_ERR    = 4'd8
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] idx_q,   idx_d;     // word index of the next write
   logic [15:0] count_q, count_d;   // program length N in words
   logic [7:0]  cnt_l_q, cnt_l_d;   // CNT_L held until CNT_H arrives
   logic [7:0]  chk_q,   chk_d;     // running payload checksum, mod 256
   logic [7:0]  lo_q,    lo_d;
   logic [7:0]  hi_q,    hi_d;

   logic        w_accept;
   logic [15:0] w_count;

   // WRITE is the only state that refuses a byte, so acceptance depends on
   // the registered state alone.
   assign w_accept = i_byte_valid && (state_q != S_WRITE);
   assign w_count  = {i_byte, cnt_l_q};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         idx_q   <= 16'h0000;
         count_q <= 16'h0000;
         cnt_l_q <= 8'h00;
         chk_q   <= 8'h00;
         lo_q    <= 8'h00;
         hi_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         cnt_l_q <= cnt_l_d;
         chk_q   <= chk_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      count_d = count_q;
      cnt_l_d = cnt_l_q;
      chk_d   = chk_q;
      lo_d    = lo_q;
      hi_d    = hi_q;

      // Outputs decode straight from the state register, so an asynchronous
      // reset forces them (including the write strobe) low immediately.
      o_byte_ready = (state_q != S_WRITE);
      o_mem_we     = (state_q == S_WRITE);
      o_mem_addr   = idx_q << 1;
      o_mem_wdata  = {hi_q, lo_q};
      o_cpu_hold   = (state_q != S_DONE);
      o_done       = (state_q == S_DONE);
      o_error      = (state_q == S_ERR);

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            // Non-SYNC bytes are silently dropped between frames.
            if (w_accept && (i_byte == c_SYNC)) begin
               state_d = S_CNT_L;
               idx_d   = 16'h0000;
               chk_d   = 8'h00;
            end
         end
         S_CNT_L: begin
            if (w_accept) begin
               cnt_l_d = i_byte;
               state_d = S_CNT_H;
            end
         end
         S_CNT_H: begin
            if (w_accept) begin
               count_d = w_count;
               idx_d   = 16'h0000;
               chk_d   = 8'h00;
               if (w_count == 16'h0000) begin
                  state_d = S_CHK;
               end else if ({1'b0, w_count} > c_MAX_WORDS) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_DATA_L;
               end
            end
         end
         S_DATA_L: begin
            if (w_accept) begin
               lo_d    = i_byte;
               chk_d   = chk_q + i_byte;
               state_d = S_DATA_H;
            end
         end
         S_DATA_H: begin
            if (w_accept) begin
               hi_d    = i_byte;
               chk_d   = chk_q + i_byte;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            idx_d = idx_q + 16'd1;
            // 17-bit compare keeps the remaining-words test free of overflow.
            if (({1'b0, idx_q} + 17'd1) < {1'b0, count_q}) begin
               state_d = S_DATA_L;
            end else begin
               state_d = S_CHK;
            end
         end
         S_CHK: begin
            if (w_accept) begin
               state_d = (i_byte == chk_q) ? S_DONE : S_ERR;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire
